// File: rtl/finger_motion_sequencer.sv
// finger_motion_sequencer
// Accepts gesture commands, maps them to five per-finger target pulse widths
// and slews each finger's width toward its target by at most STEP_US per
// servo frame tick.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | targets met, waiting for a command (cmd_ready = 1)
// RAMP  | slewing widths toward targets; new commands preempt (cmd_ready = 1)
// DONE  | one-cycle done pulse, commands held off (cmd_ready = 0)
`timescale 1ns/1ps
module finger_motion_sequencer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 50,
    parameter int STEP_US = 10,
    parameter int MIN_US  = 1000,
    parameter int MAX_US  = 2000,
    parameter int HOME_US = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_gesture,
    output logic [15:0] width_thumb,
    output logic [15:0] width_index,
    output logic [15:0] width_middle,
    output logic [15:0] width_ring,
    output logic [15:0] width_pinky,
    output logic        busy,
    output logic        done,
    output logic        cmd_err
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CW       = $clog2(TICK_DIV);

    function automatic logic [15:0] clamp_us(input int v);
        if (v < MIN_US)      return 16'(MIN_US);
        else if (v > MAX_US) return 16'(MAX_US);
        else                 return 16'(v);
    endfunction

    localparam logic [15:0] T_1600 = clamp_us(1600);
    localparam logic [15:0] T_1400 = clamp_us(1400);
    localparam logic [15:0] T_HOME = clamp_us(HOME_US);
    localparam logic [15:0] T_MAX  = clamp_us(MAX_US);
    localparam logic [15:0] T_MIN  = clamp_us(MIN_US);

    localparam logic signed [16:0] STEP_S  = 17'(STEP_US);
    localparam logic        [15:0] STEP_16 = 16'(STEP_US);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        tcnt_q;
    logic                 tick;
    logic [15:0]          w_q     [5];
    logic [15:0]          tgt_q   [5];
    logic [15:0]          g_tgt   [5];
    logic [15:0]          step_w  [5];
    logic signed [16:0]   diff    [5];
    logic                 g_known;
    logic                 all_eq;
    logic                 accept;
    logic                 cmd_err_q;

    assign tick      = (tcnt_q == CW'(TICK_DIV - 1));
    assign cmd_ready = (state_q != S_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign cmd_err   = cmd_err_q;

    assign width_thumb  = w_q[0];
    assign width_index  = w_q[1];
    assign width_middle = w_q[2];
    assign width_ring   = w_q[3];
    assign width_pinky  = w_q[4];

    // Free-running frame tick divider; never resynchronised by commands.
    always_ff @(posedge clk) begin
        if (reset)     tcnt_q <= '0;
        else if (tick) tcnt_q <= '0;
        else           tcnt_q <= tcnt_q + CW'(1);
    end

    // Gesture decode; hold and unknown codes keep the current targets.
    always_comb begin
        for (int i = 0; i < 5; i++) g_tgt[i] = tgt_q[i];
        g_known = 1'b1;
        case (cmd_gesture)
            8'h00: ;
            8'h01: for (int i = 0; i < 5; i++) g_tgt[i] = T_1600;
            8'h02: for (int i = 0; i < 5; i++) g_tgt[i] = T_1400;
            8'h03: for (int i = 0; i < 5; i++) g_tgt[i] = T_HOME;
            8'h04: for (int i = 0; i < 5; i++) g_tgt[i] = T_MAX;
            8'h05: for (int i = 0; i < 5; i++) g_tgt[i] = T_MIN;
            8'h06: begin
                for (int i = 0; i < 5; i++) g_tgt[i] = T_MAX;
                g_tgt[1] = T_MIN;
            end
            default: g_known = 1'b0;
        endcase
    end

    // Per-finger slew step toward the registered target, plus arrival detect.
    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            diff[i] = $signed({1'b0, tgt_q[i]}) - $signed({1'b0, w_q[i]});
            if (diff[i] > STEP_S)       step_w[i] = w_q[i] + STEP_16;
            else if (diff[i] < -STEP_S) step_w[i] = w_q[i] - STEP_16;
            else                        step_w[i] = tgt_q[i];
            if (w_q[i] != tgt_q[i]) all_eq = 1'b0;
        end
    end

    // Sequencer FSM with registered widths, targets and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_err_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                w_q[i]   <= T_HOME;
                tgt_q[i] <= T_HOME;
            end
        end else begin
            cmd_err_q <= 1'b0;
            if (accept) begin
                for (int i = 0; i < 5; i++) tgt_q[i] <= g_tgt[i];
                cmd_err_q <= ~g_known;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) state_q <= S_RAMP;
                end
                S_RAMP: begin
                    // The step uses pre-edge targets, so a same-edge accept
                    // only influences the following tick.
                    if (tick) begin
                        for (int i = 0; i < 5; i++) w_q[i] <= step_w[i];
                    end
                    if (!accept && all_eq) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
